// File: rtl/onehot_seq_pkg.sv
// Shared constants, phase encoding and helper functions for the one-hot sequencer.
package onehot_seq_pkg;

   localparam int MAX_STATES = 32;
   localparam int MAX_CFG_W  = 256;
   localparam int IDLE_BIT   = 0;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_WORK,
      PH_DONE,
      PH_BAD
   } phase_e;

   function automatic int done_bit(input int num_states);
      return num_states - 1;
   endfunction

   function automatic logic is_onehot(input logic [MAX_STATES-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Stage k (1-based) occupies cfg[(k-1)*dwell_w +: dwell_w].
   function automatic logic [31:0] dwell_slice(input logic [MAX_CFG_W-1:0] cfg,
                                               input int k, input int dwell_w);
      logic [MAX_CFG_W-1:0] sh;
      sh = cfg >> ((k - 1) * dwell_w);
      return sh[31:0] & ((32'd1 << dwell_w) - 32'd1);
   endfunction

endpackage

// File: rtl/onehot_dwell_cnt.sv
// Per-stage dwell counter: load on stage entry, clear outside work stages,
// otherwise count down to zero and hold.
module onehot_dwell_cnt #(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               clear_i,
   input  logic [DWELL_W-1:0] load_val_i,
   output logic [DWELL_W-1:0] cnt_o,
   output logic               zero_o
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/onehot_seq_fsm.sv
// One-hot start/done sequencer with programmable per-stage dwell and abort.
// Define ONEHOT_SEQ_ILLEGAL_CHECK_EN to add illegal-state detection and recovery.
module onehot_seq_fsm
   import onehot_seq_pkg::*;
#(
   parameter int NUM_STATES = 4,
   parameter int DWELL_W    = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   input  logic [(NUM_STATES-2)*DWELL_W-1:0] dwell_cfg,
   output logic [NUM_STATES-1:0]           state,
   output logic                            busy,
   output logic                            done,
   output logic                            aborted,
   output logic [DWELL_W-1:0]              stage_cnt,
   output logic                            err
);

   localparam int DONE_BIT = done_bit(NUM_STATES);

   logic [NUM_STATES-1:0] state_q, state_d;
   logic                  aborted_q, aborted_d;
   logic                  illegal;
   phase_e                phase;
   logic                  next_work;
   logic                  cnt_load, cnt_clear, cnt_zero;
   logic [DWELL_W-1:0]    cnt_load_val, cnt_val;
   logic [MAX_CFG_W-1:0]  cfg_ext;

   assign cfg_ext = MAX_CFG_W'(dwell_cfg);

`ifdef ONEHOT_SEQ_ILLEGAL_CHECK_EN
   logic err_q, err_d;

   assign illegal = ~is_onehot(MAX_STATES'(state_q));
   assign err_d   = err_q | illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign err = err_q;
`else
   assign illegal = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      phase = PH_BAD;
      if (illegal)
         phase = PH_BAD;
      else if (state_q[IDLE_BIT])
         phase = PH_IDLE;
      else if (state_q[DONE_BIT])
         phase = PH_DONE;
      else if (|state_q[NUM_STATES-2:1])
         phase = PH_WORK;
   end

   // Abort outranks start and dwell expiry; a work stage simply shifts to its successor.
   always_comb begin
      state_d   = state_q;
      aborted_d = 1'b0;
      case (phase)
         PH_IDLE: begin
            if (start && !abort) begin
               state_d    = '0;
               state_d[1] = 1'b1;
            end
         end
         PH_WORK: begin
            if (abort) begin
               state_d           = '0;
               state_d[IDLE_BIT] = 1'b1;
               aborted_d         = 1'b1;
            end else if (cnt_zero) begin
               state_d = state_q << 1;
            end
         end
         default: begin
            state_d           = '0;
            state_d[IDLE_BIT] = 1'b1;
         end
      endcase
   end

   assign next_work = |state_d[NUM_STATES-2:1];
   assign cnt_load  = next_work && (state_d != state_q);
   assign cnt_clear = ~next_work;

   always_comb begin
      cnt_load_val = '0;
      for (int k = 1; k <= NUM_STATES - 2; k++) begin
         if (state_d[k])
            cnt_load_val = DWELL_W'(dwell_slice(cfg_ext, k, DWELL_W));
      end
   end

   onehot_dwell_cnt #(
      .DWELL_W (DWELL_W)
   ) u_dwell_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .clear_i    (cnt_clear),
      .load_val_i (cnt_load_val),
      .cnt_o      (cnt_val),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= NUM_STATES'(1);
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         aborted_q <= aborted_d;
      end
   end

   assign state     = state_q;
   assign busy      = |state_q[NUM_STATES-2:1];
   assign done      = state_q[DONE_BIT];
   assign aborted   = aborted_q;
   assign stage_cnt = cnt_val;

endmodule
